// File: rtl/typing_game_pkg.sv
// Shared definitions for the typing game controller: state encodings,
// default letter width / start key, and a width helper.
package typing_game_pkg;

  localparam int unsigned LETTER_W_DEF = 5;
  localparam logic [LETTER_W_DEF-1:0] START_CODE_DEF = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRIME0 = 3'd1,
    ST_PRIME1 = 3'd2,
    ST_PLAY   = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  // Ceiling log2, floored at one bit so that it is always usable as a vector width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((longint'(1) << r) < longint'(value)) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/typing_game_ctrl_game_timer.sv
// Game time limit: loads GAME_CYCLES-1, counts down while enabled and
// flags expiry in the last allowed cycle. GAME_CYCLES==0 disables it.
module game_timer
  import typing_game_pkg::*;
#(
  parameter int unsigned GAME_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (GAME_CYCLES == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, clear, enable};
    assign expired = 1'b0;
  end else begin : g_on
    localparam int unsigned CNT_W = clog2(GAME_CYCLES);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(GAME_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
      if (!reset || clear) begin
        count <= LOAD;
      end else if (enable && (count != '0)) begin
        count <= count - CNT_W'(1);
      end
    end

    assign expired = enable && (count == '0);
  end

endmodule

// File: rtl/typing_game_ctrl.sv
// Player-activity controller: compares keystrokes with the current word,
// requests new words, and tracks score, lives and game time.
module typing_game_ctrl
  import typing_game_pkg::*;
#(
  parameter int unsigned LETTER_W = LETTER_W_DEF,
  parameter int unsigned WORD_LEN = 4,
  parameter int unsigned MAX_LIVES = 3,
  parameter int unsigned SCORE_W = 8,
  parameter int unsigned GAME_CYCLES = 500000000,
  parameter logic [LETTER_W-1:0] START_CODE = LETTER_W'(START_CODE_DEF)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [LETTER_W-1:0]             key_code,
  input  logic                            key_valid,
  input  logic [WORD_LEN*LETTER_W-1:0]    current_word,
  output logic                            word_req,
  output logic [2:0]                      state,
  output logic [clog2(WORD_LEN)-1:0]      letter_idx,
  output logic [SCORE_W-1:0]              score,
  output logic [clog2(MAX_LIVES+1)-1:0]   lives,
  output logic                            sw_start,
  output logic                            game_over
);

  localparam int unsigned IDX_W   = clog2(WORD_LEN);
  localparam int unsigned LIVES_W = clog2(MAX_LIVES + 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_d;
  logic [SCORE_W-1:0]   score_d;
  logic [LIVES_W-1:0]   lives_d;
  logic                 word_req_d, sw_start_d, game_over_d;
  logic                 timer_clear, expired, hit, last_letter;
  logic [LETTER_W-1:0]  letters [WORD_LEN];

  always_comb begin
    for (int unsigned i = 0; i < WORD_LEN; i++) begin
      letters[i] = current_word[i*LETTER_W +: LETTER_W];
    end
  end

  assign hit         = (key_code == letters[letter_idx]);
  assign last_letter = (letter_idx == IDX_W'(WORD_LEN - 1));
  assign state       = state_q;

  game_timer #(
    .GAME_CYCLES(GAME_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (state_q == ST_PLAY),
    .expired(expired)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = letter_idx;
    score_d     = score;
    lives_d     = lives;
    word_req_d  = 1'b0;
    sw_start_d  = sw_start;
    game_over_d = game_over;
    timer_clear = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (key_valid && (key_code == START_CODE)) begin
          state_d     = ST_PRIME0;
          idx_d       = '0;
          score_d     = '0;
          lives_d     = LIVES_W'(MAX_LIVES);
          word_req_d  = 1'b1;
          game_over_d = 1'b0;
          timer_clear = 1'b1;
        end
      end
      ST_PRIME0: begin
        state_d    = ST_PRIME1;
        word_req_d = 1'b1;
      end
      ST_PRIME1: begin
        state_d    = ST_PLAY;
        sw_start_d = 1'b1;
      end
      ST_PLAY: begin
        // Timeout takes priority: a coincident keystroke is dropped.
        if (expired) begin
          state_d     = ST_OVER;
          sw_start_d  = 1'b0;
          game_over_d = 1'b1;
        end else if (key_valid) begin
          if (hit) begin
            if (last_letter) begin
              idx_d      = '0;
              word_req_d = 1'b1;
              if (score != '1) score_d = score + SCORE_W'(1);
            end else begin
              idx_d = letter_idx + IDX_W'(1);
            end
          end else if (lives > LIVES_W'(1)) begin
            lives_d = lives - LIVES_W'(1);
          end else begin
            lives_d     = '0;
            state_d     = ST_OVER;
            sw_start_d  = 1'b0;
            game_over_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      letter_idx <= '0;
      score      <= '0;
      lives      <= LIVES_W'(MAX_LIVES);
      word_req   <= 1'b0;
      sw_start   <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state_q    <= state_d;
      letter_idx <= idx_d;
      score      <= score_d;
      lives      <= lives_d;
      word_req   <= word_req_d;
      sw_start   <= sw_start_d;
      game_over  <= game_over_d;
    end
  end

endmodule

// File: tb/tb_typing_game_ctrl.sv
// Bench for typing_game_ctrl: three parameterisations share one stimulus stream
// and are compared every cycle with a game-rule model, plus scenario checks.
module tb_typing_game_ctrl;

  localparam int NI = 3;
  localparam int PH_IDLE = 0, PH_PRIME = 1, PH_PLAY = 2, PH_OVER = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        key_valid = 1'b0;
  logic [4:0]  key_code = '0;
  logic [29:0] word6 = '0;

  always #5 clk = ~clk;

  // A: 4 letters, 3 lives, 2-bit score, no limit. B: 50-cycle limit. C: 6 letters, 5 lives.
  logic [2:0] st_a, st_b, st_c;
  logic [1:0] idx_a, idx_b;
  logic [2:0] idx_c;
  logic [1:0] sc_a;
  logic [7:0] sc_b, sc_c;
  logic [1:0] lv_a, lv_b;
  logic [2:0] lv_c;
  logic       wr_a, wr_b, wr_c, sw_a, sw_b, sw_c, go_a, go_b, go_c;

  typing_game_ctrl #(.LETTER_W(5), .WORD_LEN(4), .MAX_LIVES(3), .SCORE_W(2), .GAME_CYCLES(0))
  u_a (.clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
       .current_word(word6[19:0]), .word_req(wr_a), .state(st_a), .letter_idx(idx_a),
       .score(sc_a), .lives(lv_a), .sw_start(sw_a), .game_over(go_a));

  typing_game_ctrl #(.LETTER_W(5), .WORD_LEN(4), .MAX_LIVES(3), .SCORE_W(8), .GAME_CYCLES(50))
  u_b (.clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
       .current_word(word6[19:0]), .word_req(wr_b), .state(st_b), .letter_idx(idx_b),
       .score(sc_b), .lives(lv_b), .sw_start(sw_b), .game_over(go_b));

  typing_game_ctrl #(.LETTER_W(5), .WORD_LEN(6), .MAX_LIVES(5), .SCORE_W(8), .GAME_CYCLES(0))
  u_c (.clk(clk), .reset(reset), .key_code(key_code), .key_valid(key_valid),
       .current_word(word6), .word_req(wr_c), .state(st_c), .letter_idx(idx_c),
       .score(sc_c), .lives(lv_c), .sw_start(sw_c), .game_over(go_c));

  logic [7:0] o_st [NI], o_idx [NI], o_sc [NI], o_lv [NI];
  logic       o_wr [NI], o_sw [NI], o_go [NI];
  assign o_st[0] = {5'b0, st_a};  assign o_st[1] = {5'b0, st_b};  assign o_st[2] = {5'b0, st_c};
  assign o_idx[0] = {6'b0, idx_a}; assign o_idx[1] = {6'b0, idx_b}; assign o_idx[2] = {5'b0, idx_c};
  assign o_sc[0] = {6'b0, sc_a};  assign o_sc[1] = sc_b;          assign o_sc[2] = sc_c;
  assign o_lv[0] = {6'b0, lv_a};  assign o_lv[1] = {6'b0, lv_b};  assign o_lv[2] = {5'b0, lv_c};
  assign o_wr[0] = wr_a; assign o_wr[1] = wr_b; assign o_wr[2] = wr_c;
  assign o_sw[0] = sw_a; assign o_sw[1] = sw_b; assign o_sw[2] = sw_c;
  assign o_go[0] = go_a; assign o_go[1] = go_b; assign o_go[2] = go_c;

  int p_wl   [NI] = '{4, 4, 6};
  int p_ml   [NI] = '{3, 3, 5};
  int p_smax [NI] = '{3, 255, 255};
  int p_gc   [NI] = '{0, 50, 0};

  // Game-rule model: phase, priming countdown, letter position, score, lives, elapsed play time.
  int m_phase [NI], m_prime [NI], m_idx [NI], m_score [NI], m_lives [NI], m_elapsed [NI];
  bit m_wr [NI];

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      int ph, pr, ix, sc, lv, el, letter;
      bit wr;
      ph = m_phase[k]; pr = m_prime[k]; ix = m_idx[k]; sc = m_score[k];
      lv = m_lives[k]; el = m_elapsed[k]; wr = 1'b0;
      if (!reset) begin
        ph = PH_IDLE; pr = 0; ix = 0; sc = 0; lv = p_ml[k]; el = 0;
      end else begin
        case (ph)
          PH_IDLE, PH_OVER: begin
            if (key_valid && key_code == 5'd31) begin
              ph = PH_PRIME; pr = 2; ix = 0; sc = 0; lv = p_ml[k]; el = 0; wr = 1'b1;
            end
          end
          PH_PRIME: begin
            if (pr == 2) begin pr = 1; wr = 1'b1; end
            else ph = PH_PLAY;
          end
          default: begin
            if (p_gc[k] != 0 && el == p_gc[k] - 1) begin
              ph = PH_OVER;
            end else begin
              el = el + 1;
              if (key_valid) begin
                letter = int'((word6 >> (5 * ix)) & 30'h1f);
                if (int'(key_code) == letter) begin
                  if (ix == p_wl[k] - 1) begin
                    ix = 0; wr = 1'b1;
                    sc = (sc + 1 > p_smax[k]) ? p_smax[k] : sc + 1;
                  end else begin
                    ix = ix + 1;
                  end
                end else begin
                  lv = lv - 1;
                  if (lv == 0) ph = PH_OVER;
                end
              end
            end
          end
        endcase
      end
      m_phase[k] <= ph; m_prime[k] <= pr; m_idx[k] <= ix; m_score[k] <= sc;
      m_lives[k] <= lv; m_elapsed[k] <= el; m_wr[k] <= wr;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < NI; k++) begin
        int es;
        es = (m_phase[k] == PH_IDLE) ? 0 : (m_phase[k] == PH_PRIME) ? ((m_prime[k] == 2) ? 1 : 2) :
             (m_phase[k] == PH_PLAY) ? 3 : 4;
        checks++; if (int'(o_st[k]) != es) begin errors++; $display("FAIL mon_state[%0d] t=%0t got %0d expected %0d", k, $time, o_st[k], es); end
        checks++; if (int'(o_idx[k]) != m_idx[k]) begin errors++; $display("FAIL mon_idx[%0d] t=%0t got %0d expected %0d", k, $time, o_idx[k], m_idx[k]); end
        checks++; if (int'(o_sc[k]) != m_score[k]) begin errors++; $display("FAIL mon_score[%0d] t=%0t got %0d expected %0d", k, $time, o_sc[k], m_score[k]); end
        checks++; if (int'(o_lv[k]) != m_lives[k]) begin errors++; $display("FAIL mon_lives[%0d] t=%0t got %0d expected %0d", k, $time, o_lv[k], m_lives[k]); end
        checks++; if (o_wr[k] !== m_wr[k]) begin errors++; $display("FAIL mon_word_req[%0d] t=%0t got %0b expected %0b", k, $time, o_wr[k], m_wr[k]); end
        checks++; if (o_sw[k] !== (m_phase[k] == PH_PLAY)) begin errors++; $display("FAIL mon_sw_start[%0d] t=%0t got %0b", k, $time, o_sw[k]); end
        checks++; if (o_go[k] !== (m_phase[k] == PH_OVER)) begin errors++; $display("FAIL mon_game_over[%0d] t=%0t got %0b", k, $time, o_go[k]); end
      end
    end
  end

  task automatic press(input logic [4:0] code);
    key_code = code; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; key_valid = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    checks++; if (st_a !== 3'd0) begin errors++; $display("FAIL reset_state got %0d expected 0", st_a); end
    checks++; if (idx_a !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d expected 0", idx_a); end
    checks++; if (sc_a !== 2'd0) begin errors++; $display("FAIL reset_score got %0d expected 0", sc_a); end
    checks++; if (lv_a !== 2'd3) begin errors++; $display("FAIL reset_lives_a got %0d expected 3", lv_a); end
    checks++; if (lv_c !== 3'd5) begin errors++; $display("FAIL reset_lives_c got %0d expected 5", lv_c); end
    checks++; if ({wr_a, sw_a, go_a} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b expected 000", {wr_a, sw_a, go_a}); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start;
    logic [3:0] pat;
    word6 = {5'd30, 5'd12, 5'd20, 5'd1, 5'd7, 5'd3};
    press(5'd31);
    checks++; if (st_a !== 3'd1) begin errors++; $display("FAIL start_prime0 got %0d expected 1", st_a); end
    pat = '0;
    for (int i = 0; i < 4; i++) begin pat[i] = wr_a; @(negedge clk); end
    checks++; if (pat !== 4'b0011) begin errors++; $display("FAIL start_word_req_pattern got %b expected 0011", pat); end
    checks++; if (st_a !== 3'd3 || sw_a !== 1'b1) begin errors++; $display("FAIL start_play got state %0d sw %0b expected 3 1", st_a, sw_a); end
    checks++; if (lv_a !== 2'd3 || sc_a !== 2'd0) begin errors++; $display("FAIL start_counts got lives %0d score %0d expected 3 0", lv_a, sc_a); end
    checks++; if (st_c !== 3'd3) begin errors++; $display("FAIL start_play_c got %0d expected 3", st_c); end
  endtask

  task automatic test_perfect_word;
    int keys [4] = '{3, 7, 1, 20};
    int exp_idx [4] = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      press(5'(keys[i]));
      checks++; if (int'(idx_a) != exp_idx[i]) begin errors++; $display("FAIL word_idx%0d got %0d expected %0d", i, idx_a, exp_idx[i]); end
      checks++; if (wr_a !== (i == 3)) begin errors++; $display("FAIL word_req%0d got %0b expected %0b", i, wr_a, (i == 3)); end
    end
    checks++; if (sc_a !== 2'd1 || lv_a !== 2'd3) begin errors++; $display("FAIL word_done got score %0d lives %0d expected 1 3", sc_a, lv_a); end
    checks++; if (idx_c !== 3'd4 || sc_c !== 8'd0) begin errors++; $display("FAIL word_c got idx %0d score %0d expected 4 0", idx_c, sc_c); end
  endtask

  task automatic test_misses;
    press(5'd3);
    checks++; if (idx_a !== 2'd1) begin errors++; $display("FAIL miss_hit_idx got %0d expected 1", idx_a); end
    press(5'd9);
    checks++; if (lv_a !== 2'd2 || idx_a !== 2'd1) begin errors++; $display("FAIL miss1 got lives %0d idx %0d expected 2 1", lv_a, idx_a); end
    press(5'd9);
    checks++; if (lv_a !== 2'd1) begin errors++; $display("FAIL miss2 got lives %0d expected 1", lv_a); end
    press(5'd9);
    checks++; if (lv_a !== 2'd0 || st_a !== 3'd4) begin errors++; $display("FAIL miss_over got lives %0d state %0d expected 0 4", lv_a, st_a); end
    checks++; if (go_a !== 1'b1 || sw_a !== 1'b0 || sc_a !== 2'd1) begin errors++; $display("FAIL miss_flags got go %0b sw %0b score %0d expected 1 0 1", go_a, sw_a, sc_a); end
    checks++; if (lv_c !== 3'd1 || st_c !== 3'd3) begin errors++; $display("FAIL miss_c got lives %0d state %0d expected 1 3", lv_c, st_c); end
  endtask

  task automatic test_timeout;
    int n;
    press(5'd31);
    n = 0;
    while (!(m_phase[1] == PH_PLAY && m_elapsed[1] == 49) && n < 200) begin @(negedge clk); n++; end
    checks++; if (n >= 200) begin errors++; $display("FAIL timeout_wait got %0d cycles expected < 200", n); end
    checks++; if (st_b !== 3'd3) begin errors++; $display("FAIL timeout_last_play got %0d expected 3", st_b); end
    press(5'd9);
    checks++; if (st_b !== 3'd4 || go_b !== 1'b1 || sw_b !== 1'b0) begin errors++; $display("FAIL timeout_over got state %0d go %0b sw %0b expected 4 1 0", st_b, go_b, sw_b); end
    checks++; if (lv_b !== 2'd3) begin errors++; $display("FAIL timeout_lives got %0d expected 3", lv_b); end
    checks++; if (st_a !== 3'd3 || lv_a !== 2'd2) begin errors++; $display("FAIL timeout_a got state %0d lives %0d expected 3 2", st_a, lv_a); end
  endtask

  task automatic test_no_limit;
    repeat (1000) @(negedge clk);
    checks++; if (st_a !== 3'd3 || sw_a !== 1'b1) begin errors++; $display("FAIL no_limit got state %0d sw %0b expected 3 1", st_a, sw_a); end
  endtask

  task automatic test_saturation;
    int exp_sc [5] = '{1, 2, 3, 3, 3};
    int pulses;
    pulses = 0;
    for (int w = 0; w < 5; w++) begin
      for (int i = 0; i < 4; i++) begin
        logic [29:0] tmp;
        tmp = word6 >> (5 * i);
        press(tmp[4:0]);
        if (wr_a) pulses++;
        checks++; if (wr_a !== (i == 3)) begin errors++; $display("FAIL sat_req w%0d i%0d got %0b expected %0b", w, i, wr_a, (i == 3)); end
      end
      checks++; if (int'(sc_a) != exp_sc[w]) begin errors++; $display("FAIL sat_score w%0d got %0d expected %0d", w, sc_a, exp_sc[w]); end
      word6 = 30'($urandom);
    end
    checks++; if (pulses != 5) begin errors++; $display("FAIL sat_pulses got %0d expected 5", pulses); end
  endtask

  task automatic test_random;
    for (int c = 0; c < 400; c++) begin
      logic [29:0] tmp;
      int r;
      reset = ($urandom_range(0, 99) != 0);
      if (wr_a) word6 = 30'($urandom);
      key_valid = ($urandom_range(0, 9) < 4);
      r = $urandom_range(0, 9);
      tmp = word6 >> (5 * m_idx[0]);
      if (r < 7) key_code = tmp[4:0];
      else if (r == 7) key_code = 5'd31;
      else key_code = 5'($urandom);
      @(negedge clk);
    end
    key_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_midgame;
    word6 = {5'd30, 5'd12, 5'd20, 5'd1, 5'd7, 5'd3};
    reset = 1'b0; @(negedge clk); reset = 1'b1;
    press(5'd31);
    repeat (2) @(negedge clk);
    checks++; if (st_a !== 3'd3) begin errors++; $display("FAIL mid_play got %0d expected 3", st_a); end
    press(5'd3); press(5'd7);
    checks++; if (idx_a !== 2'd2) begin errors++; $display("FAIL mid_idx got %0d expected 2", idx_a); end
    reset = 1'b0; key_code = 5'd1; key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; reset = 1'b1;
    checks++; if (st_a !== 3'd0 || idx_a !== 2'd0 || sc_a !== 2'd0 || lv_a !== 2'd3) begin errors++; $display("FAIL mid_reset got state %0d idx %0d score %0d lives %0d expected 0 0 0 3", st_a, idx_a, sc_a, lv_a); end
    checks++; if ({wr_a, sw_a, go_a} !== 3'b000) begin errors++; $display("FAIL mid_reset_flags got %b expected 000", {wr_a, sw_a, go_a}); end
    @(negedge clk);
    checks++; if (wr_a !== 1'b0 || st_a !== 3'd0) begin errors++; $display("FAIL mid_after got word_req %0b state %0d expected 0 0", wr_a, st_a); end
  endtask

  task automatic test_restart_over;
    press(5'd31);
    repeat (2) @(negedge clk);
    press(5'd3); press(5'd7); press(5'd1); press(5'd20);
    for (int i = 0; i < 5; i++) press(5'd9);
    checks++; if (st_a !== 3'd4 || sc_a !== 2'd1) begin errors++; $display("FAIL over_a got state %0d score %0d expected 4 1", st_a, sc_a); end
    checks++; if (st_c !== 3'd4 || lv_c !== 3'd0) begin errors++; $display("FAIL over_c got state %0d lives %0d expected 4 0", st_c, lv_c); end
    press(5'd12);
    checks++; if (st_a !== 3'd4) begin errors++; $display("FAIL over_ignore got %0d expected 4", st_a); end
    press(5'd31);
    checks++; if (st_a !== 3'd1 || sc_a !== 2'd0 || lv_a !== 2'd3 || go_a !== 1'b0) begin errors++; $display("FAIL restart_a got state %0d score %0d lives %0d go %0b expected 1 0 3 0", st_a, sc_a, lv_a, go_a); end
    checks++; if (st_c !== 3'd1 || lv_c !== 3'd5 || wr_c !== 1'b1) begin errors++; $display("FAIL restart_c got state %0d lives %0d word_req %0b expected 1 5 1", st_c, lv_c, wr_c); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_perfect_word();
    test_misses();
    test_timeout();
    test_no_limit();
    test_saturation();
    test_random();
    test_reset_midgame();
    test_restart_over();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
